// File: rtl/piso_pkg.sv
// Shared definitions for the bit-serial transmitter: FSM state encoding and counter sizing.
// The PAR encoding is always defined so both build flavours share one state space.
package piso_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_PAR   = 2'd2;

    // Bit counter runs 0..WIDTH, so it needs room for the value WIDTH itself.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out transmitter; optional even parity bit when PISO_PARITY_EN is defined.
// Latency: first bit on the first en=1 edge after the load edge; one bit per en=1 edge.
// Backpressure: in_ready is low from the load until one cycle after the final bit (1-cycle gap).
module piso_serializer
    import piso_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             sout,
    output logic             sout_valid,
    output logic             sout_last,
    output logic             busy
);

    localparam int             CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0]  LAST_IDX = CW'(WIDTH - 1);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             sout_q, sout_d;
    logic             sout_valid_q, sout_valid_d;
    logic             sout_last_q, sout_last_d;
    logic             busy_q, busy_d;
    logic             in_ready_q, in_ready_d;
`ifdef PISO_PARITY_EN
    logic             par_q, par_d;
`endif

    logic load;
    logic data_fire;
    logic last_data;
    logic next_bit;

    assign load      = (state_q == ST_IDLE) && in_valid && in_ready_q;
    assign data_fire = (state_q == ST_SHIFT) && en;
    assign last_data = (cnt_q == LAST_IDX);
    assign next_bit  = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];

    // State register, shift register and counter share one reset-first block.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            shreg_q      <= '0;
            cnt_q        <= '0;
            sout_q       <= 1'b0;
            sout_valid_q <= 1'b0;
            sout_last_q  <= 1'b0;
            busy_q       <= 1'b0;
            in_ready_q   <= 1'b0;
`ifdef PISO_PARITY_EN
            par_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            cnt_q        <= cnt_d;
            sout_q       <= sout_d;
            sout_valid_q <= sout_valid_d;
            sout_last_q  <= sout_last_d;
            busy_q       <= busy_d;
            in_ready_q   <= in_ready_d;
`ifdef PISO_PARITY_EN
            par_q        <= par_d;
`endif
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (load) begin
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (en && last_data) begin
`ifdef PISO_PARITY_EN
                    state_d = ST_PAR;
`else
                    state_d = ST_IDLE;
`endif
                end
            end
            ST_PAR: begin
`ifdef PISO_PARITY_EN
                if (en) begin
                    state_d = ST_IDLE;
                end
`else
                state_d = ST_IDLE;
`endif
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Datapath and registered outputs.
    always_comb begin
        shreg_d      = shreg_q;
        cnt_d        = cnt_q;
        sout_d       = sout_q;
        sout_valid_d = 1'b0;
        sout_last_d  = 1'b0;
`ifdef PISO_PARITY_EN
        par_d        = par_q;
`endif
        if (load) begin
            shreg_d = in_data;
            cnt_d   = '0;
`ifdef PISO_PARITY_EN
            par_d   = ^in_data;
`endif
        end else if (data_fire) begin
            sout_d       = next_bit;
            sout_valid_d = 1'b1;
            cnt_d        = cnt_q + CW'(1);
            if (MSB_FIRST) begin
                shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
            end else begin
                shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
            end
`ifdef PISO_PARITY_EN
            sout_last_d  = 1'b0;
        end else if ((state_q == ST_PAR) && en) begin
            sout_d       = par_q;
            sout_valid_d = 1'b1;
            sout_last_d  = 1'b1;
`else
            sout_last_d  = last_data;
`endif
        end
        busy_d     = (state_d != ST_IDLE);
        // Lagging the IDLE state by one cycle gives the mandatory gap after a final bit.
        in_ready_d = (state_q == ST_IDLE) && !load;
    end

    assign sout       = sout_q;
    assign sout_valid = sout_valid_q;
    assign sout_last  = sout_last_q;
    assign busy       = busy_q;
    assign in_ready   = in_ready_q;

    a_last_has_valid: assert property (@(posedge clk) disable iff (!rst_n)
        sout_last |-> sout_valid);

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: MSB-first and LSB-first instances share stimulus; a queue model
// holds each instance's expected bit stream, and each scenario task checks its own timing.
module tb_piso_serializer;

    localparam int W = 8;
`ifdef PISO_PARITY_EN
    localparam bit HAS_PAR = 1'b1;
    localparam int FL      = W + 1;
`else
    localparam bit HAS_PAR = 1'b0;
    localparam int FL      = W;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         en = 1'b0;
    logic         in_valid = 1'b0;
    logic [W-1:0] in_data = '0;

    logic m_in_ready, m_sout, m_sout_valid, m_sout_last, m_busy;
    logic l_in_ready, l_sout, l_sout_valid, l_sout_last, l_busy;

    int errors = 0;
    int checks = 0;

    logic [1:0] q_m[$];
    logic [1:0] q_l[$];
    logic       last_m = 1'b0;
    logic       last_l = 1'b0;
    logic       rst_seen = 1'b1;

    always #5 clk = ~clk;

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_ready(m_in_ready),
        .in_data(in_data), .sout(m_sout), .sout_valid(m_sout_valid),
        .sout_last(m_sout_last), .busy(m_busy)
    );

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_ready(l_in_ready),
        .in_data(in_data), .sout(l_sout), .sout_valid(l_sout_valid),
        .sout_last(l_sout_last), .busy(l_busy)
    );

    always @(posedge clk) rst_seen <= !rst_n;

    // Stream monitor: every emitted bit must match the model queue; idle cycles hold sout.
    always @(negedge clk) begin
        logic [1:0] e;
        if (rst_seen) begin
            q_m.delete();
            q_l.delete();
            last_m = 1'b0;
            last_l = 1'b0;
        end else begin
            checks++;
            if (m_sout_valid === 1'b1) begin
                if (q_m.size() == 0) begin
                    errors++;
                    $display("FAIL msb_stream: unexpected bit sout=%b last=%b", m_sout, m_sout_last);
                end else begin
                    e = q_m.pop_front();
                    if ({m_sout_last, m_sout} !== e)
                        begin errors++; $display("FAIL msb_stream: got last,bit=%b%b want %b", m_sout_last, m_sout, e); end
                end
                last_m = m_sout;
            end else if (m_sout !== last_m || m_sout_last !== 1'b0 || m_sout_valid !== 1'b0) begin
                errors++;
                $display("FAIL msb_hold: sout=%b last=%b vld=%b want sout=%b last=0 vld=0", m_sout, m_sout_last, m_sout_valid, last_m);
            end
            checks++;
            if (l_sout_valid === 1'b1) begin
                if (q_l.size() == 0) begin
                    errors++;
                    $display("FAIL lsb_stream: unexpected bit sout=%b last=%b", l_sout, l_sout_last);
                end else begin
                    e = q_l.pop_front();
                    if ({l_sout_last, l_sout} !== e)
                        begin errors++; $display("FAIL lsb_stream: got last,bit=%b%b want %b", l_sout_last, l_sout, e); end
                end
                last_l = l_sout;
            end else if (l_sout !== last_l || l_sout_last !== 1'b0 || l_sout_valid !== 1'b0) begin
                errors++;
                $display("FAIL lsb_hold: sout=%b last=%b vld=%b want sout=%b last=0 vld=0", l_sout, l_sout_last, l_sout_valid, last_l);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model of a frame: data bits in the instance's order, then optional even parity.
    task automatic expect_word(input logic [W-1:0] w);
        for (int i = 0; i < W; i++) begin
            q_m.push_back({(i == W - 1) && !HAS_PAR, w[W-1-i]});
            q_l.push_back({(i == W - 1) && !HAS_PAR, w[i]});
        end
        if (HAS_PAR) begin
            q_m.push_back({1'b1, ^w});
            q_l.push_back({1'b1, ^w});
        end
    endtask

    // Waits for in_ready, then presents the word for exactly one accepting edge.
    task automatic load_word(input logic [W-1:0] w);
        int n = 0;
        while (m_in_ready !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        checks++;
        if (m_in_ready !== 1'b1 || l_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL load_wait: in_ready m=%b l=%b want 1", m_in_ready, l_in_ready);
        end
        in_valid = 1'b1;
        in_data  = w;
        expect_word(w);
        tick();
        in_valid = 1'b0;
        in_data  = W'($urandom);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b1; in_valid = 1'b1; in_data = 8'hFF;
        tick();
        tick();
        checks++;
        if ({m_in_ready, m_sout, m_sout_valid, m_sout_last, m_busy,
             l_in_ready, l_sout, l_sout_valid, l_sout_last, l_busy} !== 10'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b%b%b%b%b %b%b%b%b%b want all 0", m_in_ready, m_sout,
                     m_sout_valid, m_sout_last, m_busy, l_in_ready, l_sout, l_sout_valid, l_sout_last, l_busy);
        end
        in_valid = 1'b0; en = 1'b0; rst_n = 1'b1;
        checks++;
        if (m_in_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_early: in_ready=%b want 0", m_in_ready); end
        tick();
        checks++;
        if (m_in_ready !== 1'b1 || l_in_ready !== 1'b1 || m_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: in_ready=%b/%b busy=%b want 1/1 0", m_in_ready, l_in_ready, m_busy);
        end
    endtask

    task automatic test_msb_const_en();
        logic [W-1:0] w = 8'hA5;
        logic         exp_b;
        en = 1'b1;
        load_word(w);
        checks++;
        if (m_busy !== 1'b1 || m_in_ready !== 1'b0 || m_sout_valid !== 1'b0) begin
            errors++;
            $display("FAIL load_cycle: busy=%b in_ready=%b vld=%b want 1 0 0", m_busy, m_in_ready, m_sout_valid);
        end
        for (int i = 0; i < FL; i++) begin
            tick();
            exp_b = (i < W) ? w[W-1-i] : ^w;
            checks++;
            if (m_sout_valid !== 1'b1 || m_sout !== exp_b || m_sout_last !== (i == FL - 1)) begin
                errors++;
                $display("FAIL msb_a5 bit%0d: vld=%b sout=%b last=%b want 1 %b %b", i, m_sout_valid, m_sout, m_sout_last, exp_b, i == FL - 1);
            end
        end
        checks++;
        if (m_busy !== 1'b0 || m_in_ready !== 1'b0) begin
            errors++;
            $display("FAIL final_bit_ready: busy=%b in_ready=%b want 0 0", m_busy, m_in_ready);
        end
        en = 1'b0;
        tick();
        checks++;
        if (m_in_ready !== 1'b1 || m_sout_valid !== 1'b0) begin
            errors++;
            $display("FAIL ready_after_frame: in_ready=%b vld=%b want 1 0", m_in_ready, m_sout_valid);
        end
    endtask

    task automatic test_sparse_en();
        int k = 0;
        int bits = 0;
        en = 1'b0;
        load_word(8'hA5);
        while (bits < FL && k < 100) begin
            en       = (k % 3 == 0);
            in_valid = 1'($urandom_range(0, 1));
            in_data  = W'($urandom);
            tick();
            checks++;
            if (m_sout_valid !== en || l_sout_valid !== en) begin
                errors++;
                $display("FAIL sparse_valid k=%0d: vld=%b/%b want %b", k, m_sout_valid, l_sout_valid, en);
            end
            if (en) bits++;
            k++;
        end
        in_valid = 1'b0;
        en = 1'b0;
        checks++;
        if (bits != FL || k != 3 * FL - 2) begin
            errors++;
            $display("FAIL sparse_count: bits=%0d cycles=%0d want %0d %0d", bits, k, FL, 3 * FL - 2);
        end
        tick();
        checks++;
        if (m_in_ready !== 1'b1 || m_busy !== 1'b0) begin
            errors++;
            $display("FAIL sparse_end: in_ready=%b busy=%b want 1 0", m_in_ready, m_busy);
        end
    endtask

    task automatic test_lsb_first();
        logic [W-1:0] w = 8'h01;
        logic         exp_l;
        en = 1'b1;
        load_word(w);
        for (int i = 0; i < FL; i++) begin
            tick();
            exp_l = (i < W) ? w[i] : ^w;
            checks++;
            if (l_sout_valid !== 1'b1 || l_sout !== exp_l) begin
                errors++;
                $display("FAIL lsb_01 bit%0d: vld=%b sout=%b want 1 %b", i, l_sout_valid, l_sout, exp_l);
            end
        end
        en = 1'b0;
        tick();
    endtask

    task automatic test_reset_midframe();
        int bits = 0;
        en = 1'b1;
        load_word(8'hFF);
        tick(); tick(); tick();
        rst_n = 1'b0;
        tick();
        checks++;
        if ({m_sout_valid, m_sout_last, m_sout, m_busy, m_in_ready, l_sout_valid, l_busy} !== 7'b0) begin
            errors++;
            $display("FAIL midframe_reset: vld=%b last=%b sout=%b busy=%b rdy=%b want 0s",
                     m_sout_valid, m_sout_last, m_sout, m_busy, m_in_ready);
        end
        rst_n = 1'b1;
        tick();
        load_word(8'h0F);
        for (int i = 0; i < FL + 2; i++) begin
            tick();
            if (m_sout_valid === 1'b1) bits++;
        end
        checks++;
        if (bits != FL) begin errors++; $display("FAIL post_reset_frame: bits=%0d want %0d", bits, FL); end
        en = 1'b0;
        tick();
    endtask

    task automatic test_frame_end();
        logic [W-1:0] words [2] = '{8'h07, 8'h03};
        logic         pars  [2] = '{1'b1, 1'b0};
        for (int n = 0; n < 2; n++) begin
            en = 1'b1;
            load_word(words[n]);
            for (int i = 0; i < FL; i++) tick();
`ifdef PISO_PARITY_EN
            checks++;
            if (m_sout !== pars[n] || l_sout !== pars[n] || m_sout_last !== 1'b1 || m_sout_valid !== 1'b1) begin
                errors++;
                $display("FAIL parity %h: sout=%b/%b last=%b vld=%b want %b 1 1", words[n], m_sout, l_sout, m_sout_last, m_sout_valid, pars[n]);
            end
`else
            checks++;
            if (m_sout_last !== 1'b1 || m_sout !== words[n][0] || pars[n] !== ^words[n]) begin
                errors++;
                $display("FAIL last_data_bit %h: sout=%b last=%b want %b 1", words[n], m_sout, m_sout_last, words[n][0]);
            end
`endif
            tick();
            checks++;
            if (m_sout_valid !== 1'b0 || l_sout_valid !== 1'b0) begin
                errors++;
                $display("FAIL extra_bit %h: vld=%b/%b want 0", words[n], m_sout_valid, l_sout_valid);
            end
            en = 1'b0;
        end
    endtask

    task automatic test_random();
        for (int f = 0; f < 12; f++) begin
            int bits = 0;
            int k = 0;
            en = 1'($urandom_range(0, 1));
            load_word(W'($urandom));
            while (bits < FL && k < 200) begin
                en       = ($urandom_range(0, 2) != 0);
                in_valid = 1'($urandom_range(0, 1));
                in_data  = W'($urandom);
                tick();
                checks++;
                if (m_sout_valid !== en || l_sout_valid !== en) begin
                    errors++;
                    $display("FAIL rand_valid f%0d: vld=%b/%b want %b", f, m_sout_valid, l_sout_valid, en);
                end
                if (en) bits++;
                k++;
            end
            in_valid = 1'b0;
            checks++;
            if (bits != FL || m_in_ready !== 1'b0) begin
                errors++;
                $display("FAIL rand_frame f%0d: bits=%0d in_ready=%b want %0d 0", f, bits, m_in_ready, FL);
            end
        end
        en = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        test_reset();
        test_msb_const_en();
        test_sparse_en();
        test_lsb_first();
        test_reset_midframe();
        test_frame_end();
        test_random();
        checks++;
        if (q_m.size() != 0 || q_l.size() != 0) begin
            errors++;
            $display("FAIL leftover_bits: msb=%0d lsb=%0d want 0 0", q_m.size(), q_l.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
